sobel_window_gen: RTL and testbench

- Streaming 3x3 window generator, directly upstream of main_sobel.
- Accepts a raster-order 8-bit grayscale pixel stream (one pixel per accepted cycle) and buffers the two previous image lines.
- Emits the 3x3 neighbourhood on the 72-bit mem_bus_out bus that main_sobel consumes, qualified by win_valid.
- Replaces the file-based memory_reader for the synthesizable image path.

---
 rtl/sobel_window_gen.sv | 137 +++++++++++++
 tb/tb_sobel_window_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
//
// Streaming 3x3 neighbourhood generator that feeds main_sobel. Pixels arrive
// in raster order, one per accepted cycle. Two line buffers keep the previous
// two image lines, and three 3-deep column shift registers hold the window.
// A complete window is presented one cycle after the pixel that completes it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   pix_in       incoming pixel (PIX_W bits)
//   pix_valid    pix_in is accepted this cycle (no backpressure)
//   sof          start of frame, sampled with pix_valid; pix_in becomes (0,0)
//   mem_bus_out  3x3 window, P0 (top-left, [9*PIX_W-1 -: PIX_W]) .. P8
//                (current pixel, [PIX_W-1:0]), row-major
//   win_valid    mem_bus_out holds a new complete window this cycle
//   frame_done   one-cycle pulse alongside the last window of a frame
//   row_idx      row of the most recently accepted pixel
//   col_idx      column of the most recently accepted pixel
// -----------------------------------------------------------------------------
module sobel_window_gen #(
    parameter  int IMG_W = 256,
    parameter  int IMG_H = 256,
    parameter  int PIX_W = 8,
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [9*PIX_W-1:0] mem_bus_out,
    output logic               win_valid,
    output logic               frame_done,
    output logic [ROW_W-1:0]   row_idx,
    output logic [COL_W-1:0]   col_idx
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0] col_p0;
    logic [ROW_W-1:0] row_p0;

    // Line buffers: lb1 holds line r-1, lb2 holds line r-2.
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    // Window columns, index 0 = column c-2 (oldest), index 2 = column c.
    logic [2:0][PIX_W-1:0] top_p1;
    logic [2:0][PIX_W-1:0] mid_p1;
    logic [2:0][PIX_W-1:0] bot_p1;

    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   nxt_col;
    logic [ROW_W-1:0]   nxt_row;
    logic [PIX_W-1:0]   lb1_rd;
    logic [PIX_W-1:0]   lb2_rd;
    logic [9*PIX_W-1:0] nxt_win;
    logic               win_fire;
    logic               last_pix;

    always_comb begin
        // sof forces the incoming pixel to (0,0) regardless of the counters,
        // which silently drops any partially received frame.
        cur_col = sof ? '0 : col_p0;
        cur_row = sof ? '0 : row_p0;

        lb1_rd = lb1[cur_col];
        lb2_rd = lb2[cur_col];

        // Window as it will look once the current column has shifted in.
        nxt_win = {top_p1[1], top_p1[2], lb2_rd,
                   mid_p1[1], mid_p1[2], lb1_rd,
                   bot_p1[1], bot_p1[2], pix_in};

        // Gating on row/col keeps stale line-buffer contents and columns from
        // the previous line out of every valid window.
        win_fire = pix_valid && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

        nxt_col = cur_col + COL_W'(1);
        nxt_row = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        end
    end

    // Line-buffer RAM: read-before-write cascade pix_in -> lb1 -> lb2.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[cur_col] <= pix_in;
            lb2[cur_col] <= lb1_rd;
        end
    end

    // ---- stage p0 -> p1: counters, window shift and registered outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_p0      <= '0;
            row_p0      <= '0;
            top_p1      <= '0;
            mid_p1      <= '0;
            bot_p1      <= '0;
            mem_bus_out <= '0;
            win_valid   <= 1'b0;
            frame_done  <= 1'b0;
            row_idx     <= '0;
            col_idx     <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                top_p1  <= {lb2_rd, top_p1[2:1]};
                mid_p1  <= {lb1_rd, mid_p1[2:1]};
                bot_p1  <= {pix_in, bot_p1[2:1]};
                col_p0  <= nxt_col;
                row_p0  <= nxt_row;
                row_idx <= cur_row;
                col_idx <= cur_col;
                // mem_bus_out only loads on a real window so it holds
                // between windows, including across line wraps.
                if (win_fire) begin
                    mem_bus_out <= nxt_win;
                    win_valid   <= 1'b1;
                    frame_done  <= last_pix;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
`timescale 1ns/1ps
module tb_sobel_window_gen;

    localparam int SW = 5;
    localparam int SH = 4;
    localparam int LW = 256;
    localparam int LH = 256;

    typedef struct packed {
        logic [71:0] w;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small 5x4 instance
    logic        rst_s = 1'b1;
    logic [7:0]  s_pix_in = '0;
    logic        s_pix_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [71:0] s_mem_bus_out;
    logic        s_win_valid;
    logic        s_frame_done;
    logic [1:0]  s_row_idx;
    logic [2:0]  s_col_idx;

    // Default 256x256 instance
    logic        rst_l = 1'b1;
    logic [7:0]  l_pix_in = '0;
    logic        l_pix_valid = 1'b0;
    logic        l_sof = 1'b0;
    logic [71:0] l_mem_bus_out;
    logic        l_win_valid;
    logic        l_frame_done;
    logic [7:0]  l_row_idx;
    logic [7:0]  l_col_idx;

    sobel_window_gen #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8)) u_small (
        .clk(clk), .rst(rst_s), .pix_in(s_pix_in), .pix_valid(s_pix_valid),
        .sof(s_sof), .mem_bus_out(s_mem_bus_out), .win_valid(s_win_valid),
        .frame_done(s_frame_done), .row_idx(s_row_idx), .col_idx(s_col_idx)
    );

    sobel_window_gen u_large (
        .clk(clk), .rst(rst_l), .pix_in(l_pix_in), .pix_valid(l_pix_valid),
        .sof(l_sof), .mem_bus_out(l_mem_bus_out), .win_valid(l_win_valid),
        .frame_done(l_frame_done), .row_idx(l_row_idx), .col_idx(l_col_idx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- small-instance model and scoreboard ----------------
    logic [7:0]  img_s [SH][SW];
    int          ms_r = 0, ms_c = 0;
    int          exp_ri = 0, exp_ci = 0;
    exp_t        q_s[$];
    logic [71:0] win_log[$];
    int          win_cnt = 0, fd_cnt = 0, hi_cnt = 0;
    logic [71:0] fd_win = '0;
    logic [71:0] last_s = '0;
    logic        pv_prev = 1'b0;
    int          b_win, b_fd, b_hi;

    task automatic send_s(input logic [7:0] p, input logic sf, input int gap);
        exp_t e;
        s_pix_in    = p;
        s_pix_valid = 1'b1;
        s_sof       = sf;
        if (sf) begin ms_r = 0; ms_c = 0; end
        img_s[ms_r][ms_c] = p;
        if (ms_r >= 2 && ms_c >= 2) begin
            e.w = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w = {e.w[63:0], img_s[ms_r-2+i][ms_c-2+j]};
            e.fd = (ms_r == SH-1) && (ms_c == SW-1);
            q_s.push_back(e);
        end
        exp_ri = ms_r;
        exp_ci = ms_c;
        if (ms_c == SW-1) begin
            ms_c = 0;
            ms_r = (ms_r == SH-1) ? 0 : ms_r + 1;
        end else begin
            ms_c++;
        end
        @(posedge clk); #1;
        chk("row_idx", 80'(s_row_idx), 80'(exp_ri));
        chk("col_idx", 80'(s_col_idx), 80'(exp_ci));
        s_pix_valid = 1'b0;
        s_sof       = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame_s(input logic [7:0] off, input logic first_sof, input int gap);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                send_s(8'(r*16 + c) + off, first_sof && r == 0 && c == 0, gap);
    endtask

    task automatic begin_test();
        b_win = win_cnt;
        b_fd  = fd_cnt;
        b_hi  = hi_cnt;
    endtask

    task automatic end_test(input string name, input int nwin, input int nfd);
        logic ok;
        repeat (3) begin @(posedge clk); #1; end
        ok = (q_s.size() == 0);
        chk({name, "_no_missing_windows"}, 80'(ok), 80'(1));
        chk({name, "_window_count"}, 80'(win_cnt - b_win), 80'(nwin));
        chk({name, "_frame_done_count"}, 80'(fd_cnt - b_fd), 80'(nfd));
        q_s.delete();
    endtask

    initial begin : mon_small
        exp_t e;
        logic ok;
        logic hi;
        forever begin
            @(negedge clk);
            if (!rst_s) begin
                last_s  = '0;
                pv_prev = 1'b0;
            end else begin
                if (s_win_valid) begin
                    chk("win_after_idle", 80'(pv_prev), 80'(1));
                    ok = (q_s.size() > 0);
                    chk("window_expected", 80'(ok), 80'(1));
                    if (ok) begin
                        e = q_s.pop_front();
                        chk("window", 80'(s_mem_bus_out), 80'(e.w));
                        chk("frame_done", 80'(s_frame_done), 80'(e.fd));
                    end
                    win_log.push_back(s_mem_bus_out);
                    win_cnt++;
                    if (s_frame_done) begin
                        fd_cnt++;
                        fd_win = s_mem_bus_out;
                    end
                    hi = 1'b1;
                    for (int k = 0; k < 9; k++)
                        if (s_mem_bus_out[k*8+7] == 1'b0) hi = 1'b0;
                    if (hi) hi_cnt++;
                    last_s = s_mem_bus_out;
                end else begin
                    chk("frame_done_without_window", 80'(s_frame_done), 80'(0));
                    chk("bus_hold", 80'(s_mem_bus_out), 80'(last_s));
                end
                pv_prev = s_pix_valid;
            end
        end
    end

    // ---------------- large-instance model and scoreboard ----------------
    logic [7:0] img_l [LH][LW];
    exp_t       q_l[$];
    int         cnt_l = 0, fdcnt_l = 0;

    initial begin : mon_large
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (rst_l && l_win_valid) begin
                ok = (q_l.size() > 0);
                chk("large_window_expected", 80'(ok), 80'(1));
                if (ok) begin
                    e = q_l.pop_front();
                    chk("large_window", {7'd0, l_frame_done, l_mem_bus_out}, {7'd0, e.fd, e.w});
                end
                cnt_l++;
                if (l_frame_done) fdcnt_l++;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_s = 1'b1;
        rst_l = 1'b1;
        #1;
        rst_s = 1'b0;
        rst_l = 1'b0;
        #1;
        chk("reset_bus",        80'(s_mem_bus_out), 80'(0));
        chk("reset_win_valid",  80'(s_win_valid),   80'(0));
        chk("reset_frame_done", 80'(s_frame_done),  80'(0));
        chk("reset_row_idx",    80'(s_row_idx),     80'(0));
        chk("reset_col_idx",    80'(s_col_idx),     80'(0));
        chk("reset_large_bus",  80'(l_mem_bus_out), 80'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_s = 1'b1;
        rst_l = 1'b1;

        fork
            begin : small_tests
                // Continuous ramp frame
                begin_test();
                send_frame_s(8'h00, 1'b1, 0);
                end_test("cont", 6, 1);
                chk("cont_first_window", 80'(win_log[b_win]), 80'(72'h00_01_02_10_11_12_20_21_22));
                chk("cont_fd_window", 80'(fd_win), 80'(72'h12_13_14_22_23_24_32_33_34));

                // Same frame with an idle cycle after every pixel
                begin_test();
                send_frame_s(8'h00, 1'b1, 1);
                end_test("gap", 6, 1);
                chk("gap_first_window", 80'(win_log[b_win]), 80'(72'h00_01_02_10_11_12_20_21_22));
                chk("gap_fd_window", 80'(fd_win), 80'(72'h12_13_14_22_23_24_32_33_34));

                // Back-to-back frames, second one offset by 0x80
                begin_test();
                send_frame_s(8'h00, 1'b1, 0);
                send_frame_s(8'h80, 1'b1, 0);
                end_test("b2b", 12, 2);
                chk("b2b_second_frame_only_windows", 80'(hi_cnt - b_hi), 80'(6));
                chk("b2b_second_first_window", 80'(win_log[b_win+6]), 80'(72'h80_81_82_90_91_92_a0_a1_a2));
                chk("b2b_fd_window", 80'(fd_win), 80'(72'h92_93_94_a2_a3_a4_b2_b3_b4));

                // sof reasserted at (2,3): one window from the aborted frame, six from the new one
                begin_test();
                for (int i = 0; i < 2*SW + 3; i++)
                    send_s(8'((i/SW)*16 + (i%SW)), i == 0, 0);
                send_frame_s(8'h40, 1'b1, 0);
                end_test("resof", 7, 1);
                chk("resof_old_window", 80'(win_log[b_win]), 80'(72'h00_01_02_10_11_12_20_21_22));
                chk("resof_new_first_window", 80'(win_log[b_win+1]), 80'(72'h40_41_42_50_51_52_60_61_62));
                chk("resof_fd_window", 80'(fd_win), 80'(72'h52_53_54_62_63_64_72_73_74));

                // Asynchronous reset while pixel (1,4) is on the inputs
                begin_test();
                for (int i = 0; i < SW + 4; i++)
                    send_s(8'((i/SW)*16 + (i%SW)), i == 0, 0);
                s_pix_in    = 8'h14;
                s_pix_valid = 1'b1;
                #2;
                rst_s = 1'b0;
                #1;
                chk("async_rst_bus",        80'(s_mem_bus_out), 80'(0));
                chk("async_rst_win_valid",  80'(s_win_valid),   80'(0));
                chk("async_rst_frame_done", 80'(s_frame_done),  80'(0));
                chk("async_rst_row_idx",    80'(s_row_idx),     80'(0));
                chk("async_rst_col_idx",    80'(s_col_idx),     80'(0));
                s_pix_valid = 1'b0;
                q_s.delete();
                ms_r = 0; ms_c = 0; exp_ri = 0; exp_ci = 0;
                repeat (2) @(posedge clk);
                #1;
                rst_s = 1'b1;
                begin_test();
                send_frame_s(8'h00, 1'b0, 0);
                end_test("post_rst", 6, 1);
                chk("post_rst_first_window", 80'(win_log[b_win]), 80'(72'h00_01_02_10_11_12_20_21_22));
                chk("post_rst_fd_window", 80'(fd_win), 80'(72'h12_13_14_22_23_24_32_33_34));
            end

            begin : large_test
                exp_t e;
                logic ok;
                for (int r = 0; r < LH; r++) begin
                    for (int c = 0; c < LW; c++) begin
                        l_pix_in    = 8'($urandom);
                        l_pix_valid = 1'b1;
                        l_sof       = (r == 0 && c == 0);
                        img_l[r][c] = l_pix_in;
                        if (r >= 2 && c >= 2) begin
                            e.w = '0;
                            for (int i = 0; i < 3; i++)
                                for (int j = 0; j < 3; j++)
                                    e.w = {e.w[63:0], img_l[r-2+i][c-2+j]};
                            e.fd = (r == LH-1) && (c == LW-1);
                            q_l.push_back(e);
                        end
                        @(posedge clk); #1;
                    end
                end
                l_pix_valid = 1'b0;
                l_sof       = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                ok = (q_l.size() == 0);
                chk("large_no_missing_windows", 80'(ok), 80'(1));
                chk("large_window_count", 80'(cnt_l), 80'((LH-2)*(LW-2)));
                chk("large_frame_done_count", 80'(fdcnt_l), 80'(1));
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
